// File: rtl/judge_vote_if.sv
// judge_vote_if: classifier sample bus and decided-character result bus
interface judge_vote_if #(
  parameter int IDX_W = 4,
  parameter int DIFF_W = 16,
  parameter int CNT_W = 8,
  parameter int SLOT_W = 3
);
  logic [IDX_W-1:0] char_index;
  logic [DIFF_W-1:0] char_diff;
  logic char_valid;
  logic [IDX_W-1:0] result_index;
  logic [SLOT_W-1:0] result_slot;
  logic [1:0] result_mode;
  logic [CNT_W-1:0] result_hits;
  logic result_valid;
  logic result_ready;
  modport master (
    output char_index, char_diff, char_valid, result_ready,
    input result_index, result_slot, result_mode, result_hits, result_valid
  );
  modport slave (
    input char_index, char_diff, char_valid, result_ready,
    output result_index, result_slot, result_mode, result_hits, result_valid
  );
endinterface

// File: rtl/judge_vote.sv
// judge_vote: per-slot character decision by vote count, same-class run or timeout argmax
module judge_vote #(
  parameter int NUM_CLASS = 11,
  parameter int IDX_W = 4,
  parameter int DIFF_W = 16,
  parameter int CNT_W = 8,
  parameter int CONT_W = 4,
  parameter int TMO_W = 16,
  parameter int NUM_CHARS = 7,
  parameter int SLOT_W = 3
) (
  input logic clk,
  input logic rst,
  judge_vote_if.slave bus,
  input logic [DIFF_W-1:0] max_diff,
  input logic [CONT_W-1:0] min_continue,
  input logic [CNT_W-1:0] min_counter,
  input logic [TMO_W-1:0] timeout,
  input logic plate_start,
  output logic busy,
  output logic plate_done
);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  localparam logic [IDX_W:0] NCLS = (IDX_W+1)'(NUM_CLASS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CONT_W-1:0] RUN_MAX = '1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHARS-1);
  state_t state, state_nx;
  logic [CNT_W-1:0] hist [NUM_CLASS];
  logic [CONT_W-1:0] run, run_new, eff_cont;
  logic [IDX_W-1:0] last, best_idx;
  logic [TMO_W-1:0] timer;
  logic [SLOT_W-1:0] slot;
  logic [CNT_W-1:0] h_cur, h_new, eff_cnt, best_cnt;
  logic vld, qual, cnt_hit, run_hit, hit, tmo, decide, hs, last_slot;
  assign busy = state != IDLE;
  assign vld = state == COUNT && bus.char_valid && {1'b0, bus.char_index} < NCLS;
  assign h_cur = vld ? hist[bus.char_index] : '0;
  assign h_new = h_cur == CNT_MAX ? h_cur : h_cur + CNT_W'(1);
  assign eff_cnt = min_counter == '0 ? CNT_W'(1) : min_counter;
  assign eff_cont = min_continue == '0 ? CONT_W'(1) : min_continue;
  assign qual = bus.char_diff < max_diff;
  assign run_new = !qual ? '0 :
                   (bus.char_index == last && run != '0) ? (run == RUN_MAX ? run : run + CONT_W'(1)) :
                   CONT_W'(1);
  assign cnt_hit = vld && h_new >= eff_cnt;
  assign run_hit = vld && qual && run_new >= eff_cont;
  assign hit = cnt_hit || run_hit;
  assign tmo = state == COUNT && timeout != '0 && timer == timeout - TMO_W'(1);
  assign decide = hit || tmo;
  assign hs = state == HOLD && bus.result_valid && bus.result_ready && !plate_start;
  assign last_slot = slot == LAST_SLOT;
  // histogram argmax for the timeout fallback; strict compare keeps the lowest index on ties
  always_comb begin
    best_idx = '0;
    best_cnt = hist[0];
    for (int i = 1; i < NUM_CLASS; i++)
      if (hist[i] > best_cnt) begin
        best_idx = IDX_W'(i);
        best_cnt = hist[i];
      end
  end
  // next state: abort wins, then decision, then consumer accept
  always_comb begin
    state_nx = state;
    state_nx = plate_start ? COUNT :
               decide ? HOLD :
               hs ? (last_slot ? IDLE : COUNT) : state;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // vote histogram, run tracker and slot timer; cleared on every entry to COUNT
  always_ff @(posedge clk) begin
    if (rst) last <= '0;
    else if (vld) last <= bus.char_index;
    if (rst || plate_start || hs) begin
      for (int i = 0; i < NUM_CLASS; i++) hist[i] <= '0;
      run <= '0;
      timer <= '0;
    end else if (state == COUNT) begin
      timer <= timer + TMO_W'(1);
      if (vld) begin
        hist[bus.char_index] <= h_new;
        run <= run_new;
      end
    end
  end
  // registered result, slot sequencing and end-of-plate pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result_valid <= 1'b0;
      bus.result_index <= '0;
      bus.result_slot <= '0;
      bus.result_mode <= '0;
      bus.result_hits <= '0;
      slot <= '0;
      plate_done <= 1'b0;
    end else begin
      plate_done <= hs && last_slot;
      if (plate_start) begin
        bus.result_valid <= 1'b0;
        slot <= '0;
      end else if (decide) begin
        bus.result_valid <= 1'b1;
        bus.result_index <= hit ? bus.char_index : best_idx;
        bus.result_hits <= hit ? h_new : best_cnt;
        bus.result_mode <= hit ? {run_hit, cnt_hit} : 2'b00;
        bus.result_slot <= slot;
      end else if (hs) begin
        bus.result_valid <= 1'b0;
        if (!last_slot) slot <= slot + SLOT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_judge_vote.sv
// tb_judge_vote: directed checks of count, run, timeout, backpressure, sequencing and abort
module tb_judge_vote;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic plate_start = 1'b0;
  logic busy, plate_done;
  logic [15:0] max_diff = '0;
  logic [3:0] min_continue = '0;
  logic [7:0] min_counter = '0;
  logic [15:0] timeout = '0;
  int total = 0;
  int passed = 0;
  int fails = 0;
  judge_vote_if bus ();
  judge_vote dut (
    .clk(clk), .rst(rst), .bus(bus), .max_diff(max_diff), .min_continue(min_continue),
    .min_counter(min_counter), .timeout(timeout), .plate_start(plate_start),
    .busy(busy), .plate_done(plate_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_res(input string tag, input int idx, input int mode, input int hits, input int slot);
    check({tag, ".valid"}, 32'(bus.result_valid), 1);
    check({tag, ".index"}, 32'(bus.result_index), idx);
    check({tag, ".mode"}, 32'(bus.result_mode), mode);
    check({tag, ".hits"}, 32'(bus.result_hits), hits);
    check({tag, ".slot"}, 32'(bus.result_slot), slot);
  endtask
  task automatic sample(input int idx, input int diff);
    bus.char_valid = 1'b1;
    bus.char_index = 4'(idx);
    bus.char_diff = 16'(diff);
    tick();
    bus.char_valid = 1'b0;
  endtask
  task automatic accept();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
  endtask
  task automatic start();
    plate_start = 1'b1;
    tick();
    plate_start = 1'b0;
  endtask
  initial begin
    bus.char_valid = 1'b0;
    bus.char_index = '0;
    bus.char_diff = '0;
    bus.result_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst.valid", 32'(bus.result_valid), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(plate_done), 0);
    check("rst.index", 32'(bus.result_index), 0);
    min_counter = 8'd3;
    min_continue = 4'd15;
    max_diff = 16'd0;
    start();
    check("start.busy", 32'(busy), 1);
    sample(5, 0);
    sample(2, 0);
    sample(5, 0);
    check("cnt.early", 32'(bus.result_valid), 0);
    sample(5, 0);
    chk_res("cnt", 5, 1, 3, 0);
    for (int i = 0; i < 10; i++) sample(5, 0);
    chk_res("bp", 5, 1, 3, 0);
    accept();
    check("bp.accept", 32'(bus.result_valid), 0);
    sample(5, 0);
    sample(5, 0);
    check("clr.hist", 32'(bus.result_valid), 0);
    sample(5, 0);
    chk_res("cnt2", 5, 1, 3, 1);
    min_continue = 4'd4;
    max_diff = 16'd100;
    min_counter = 8'd200;
    accept();
    for (int i = 0; i < 3; i++) sample(7, 50);
    check("run.early", 32'(bus.result_valid), 0);
    sample(7, 50);
    chk_res("run", 7, 2, 4, 2);
    accept();
    sample(7, 50);
    sample(7, 50);
    sample(7, 150);
    for (int i = 0; i < 3; i++) sample(7, 50);
    check("run.reset", 32'(bus.result_valid), 0);
    sample(7, 50);
    chk_res("run2", 7, 2, 7, 3);
    min_counter = 8'd1;
    min_continue = 4'd15;
    max_diff = 16'd0;
    accept();
    sample(12, 0);
    check("bad.idx", 32'(bus.result_valid), 0);
    sample(9, 0);
    chk_res("slot4", 9, 1, 1, 4);
    start();
    check("abort.valid", 32'(bus.result_valid), 0);
    check("abort.busy", 32'(busy), 1);
    min_counter = 8'd0;
    sample(6, 0);
    chk_res("minc0", 6, 1, 1, 0);
    min_counter = 8'd200;
    timeout = 16'd20;
    accept();
    sample(3, 0);
    sample(3, 0);
    sample(8, 0);
    sample(8, 0);
    sample(1, 0);
    repeat (14) tick();
    check("tmo.early", 32'(bus.result_valid), 0);
    tick();
    chk_res("tmo", 3, 0, 2, 1);
    accept();
    repeat (19) tick();
    check("tmo0.early", 32'(bus.result_valid), 0);
    tick();
    chk_res("tmo0", 0, 0, 0, 2);
    timeout = 16'd0;
    min_counter = 8'd0;
    start();
    bus.result_ready = 1'b1;
    for (int s = 0; s < 7; s++) begin
      sample(1, 0);
      chk_res("seq", 1, 1, 1, s);
      check("seq.done_low", 32'(plate_done), 0);
      tick();
      check("seq.accept", 32'(bus.result_valid), 0);
    end
    check("seq.done", 32'(plate_done), 1);
    check("seq.idle", 32'(busy), 0);
    tick();
    check("seq.done_pulse", 32'(plate_done), 0);
    bus.result_ready = 1'b0;
    start();
    sample(9, 0);
    accept();
    sample(9, 0);
    chk_res("pre_rst", 9, 1, 1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2.valid", 32'(bus.result_valid), 0);
    check("rst2.index", 32'(bus.result_index), 0);
    check("rst2.mode", 32'(bus.result_mode), 0);
    check("rst2.hits", 32'(bus.result_hits), 0);
    check("rst2.slot", 32'(bus.result_slot), 0);
    check("rst2.busy", 32'(busy), 0);
    check("rst2.done", 32'(plate_done), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
